// File: rtl/instr_decode_queue_if.sv
// ---------------------------------------------------------------------------
// instr_decode_queue_if
// Bundles the fetch-side handshake, the execute-side handshake and the decoded
// head-entry fields of instr_decode_queue.
//   slave  : the queue itself (accepts instructions, drives decoded fields)
//   master : the environment (fetch producer + execute consumer)
// Signals:
//   in_valid/in_ready/in_instr/in_pc   fetch -> queue handshake and payload
//   out_valid/out_ready                queue -> execute handshake
//   opcode..instr_index, imm_ext,
//   jump_target, instr_class, out_pc,
//   illegal                            decoded head entry (zero when empty)
// ---------------------------------------------------------------------------
interface instr_decode_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      opcode;
  logic [4:0]      rs_addr;
  logic [4:0]      rt_addr;
  logic [4:0]      rd_addr;
  logic [4:0]      shamt;
  logic [5:0]      func;
  logic [15:0]     imm;
  logic [XLEN-1:0] imm_ext;
  logic [25:0]     instr_index;
  logic [XLEN-1:0] jump_target;
  logic [1:0]      instr_class;
  logic [XLEN-1:0] out_pc;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, opcode, rs_addr, rt_addr, rd_addr, shamt, func,
           imm, imm_ext, instr_index, jump_target, instr_class, out_pc, illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, opcode, rs_addr, rt_addr, rd_addr, shamt, func,
           imm, imm_ext, instr_index, jump_target, instr_class, out_pc, illegal
  );
endinterface

// File: rtl/instr_decode_queue.sv
// ---------------------------------------------------------------------------
// instr_decode_queue
// DEPTH-entry in-order queue of {instruction, pc} between fetch and execute.
// The head entry is presented fully decoded (MIPS raw fields, extended
// immediate, jump target, instruction class). Decoded outputs are purely
// combinational from the head and read zero whenever the queue is empty.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (clears queue and storage)
//   flush        synchronous flush, beats push and pop
//   bus          instr_decode_queue_if.slave (handshakes + decoded fields)
//   illegal_seen sticky flag, present only with DECODE_ILLEGAL_EN
//
// Optional feature macro: DECODE_ILLEGAL_EN
//   defined   : illegal flags unsupported head opcodes; illegal_seen port
//               latches any pop of an illegal entry until reset.
//   undefined : illegal tied 0, no illegal_seen register or port.
//
// Parameters: XLEN (>= 32), DEPTH (power of 2, >= 2).
// ---------------------------------------------------------------------------
module instr_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  instr_decode_queue_if.slave  bus
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic                 illegal_seen
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HI_W  = XLEN - 28;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      instr_q [DEPTH];
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             push;
  logic             pop;
  logic [31:0]      head_instr;
  logic [XLEN-1:0]  head_pc;
  logic [5:0]       head_op;
  logic [HI_W-1:0]  jump_hi;

  // Immediate extension: logical ops zero-extend, LUI places imm in the upper
  // half and sign-extends that 32-bit value, everything else sign-extends.
  function automatic logic [XLEN-1:0] ext_imm(input logic [5:0] op,
                                               input logic [15:0] imm16);
    logic signed [15:0] simm;
    logic signed [31:0] slui;
    simm = imm16;
    slui = {imm16, 16'h0000};
    case (op)
      6'h0C, 6'h0D, 6'h0E: ext_imm = XLEN'(imm16);
      6'h0F:               ext_imm = XLEN'(slui);
      default:             ext_imm = XLEN'(simm);
    endcase
  endfunction

  function automatic logic [1:0] classify(input logic [5:0] op);
    case (op)
      6'h00:        classify = 2'b00;
      6'h02, 6'h03: classify = 2'b01;
      default:      classify = 2'b10;
    endcase
  endfunction

`ifdef DECODE_ILLEGAL_EN
  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
      6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B:
        is_legal_op = 1'b1;
      default:
        is_legal_op = 1'b0;
    endcase
  endfunction
`endif

  // Handshake flags come from the registered count only, so out_ready never
  // reaches in_ready combinationally (a full queue refuses even while popping).
  assign bus.in_ready  = (count != FULL_CNT);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Queue storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (flush) begin
      // Storage is left intact; outputs are masked by out_valid.
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= bus.in_instr;
        pc_q[wr_ptr]    <= bus.in_pc;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Head decode
  always_comb begin
    head_instr = instr_q[rd_ptr];
    head_pc    = pc_q[rd_ptr];
    head_op    = head_instr[31:26];
    // Upper bits of pc+4: bit 28 receives a carry only when pc[27:2] is all
    // ones, so the low adder bits never need to exist.
    jump_hi    = head_pc[XLEN-1:28] + HI_W'(&head_pc[27:2]);

    bus.opcode      = '0;
    bus.rs_addr     = '0;
    bus.rt_addr     = '0;
    bus.rd_addr     = '0;
    bus.shamt       = '0;
    bus.func        = '0;
    bus.imm         = '0;
    bus.imm_ext     = '0;
    bus.instr_index = '0;
    bus.jump_target = '0;
    bus.instr_class = '0;
    bus.out_pc      = '0;
    bus.illegal     = 1'b0;

    if (bus.out_valid) begin
      bus.opcode      = head_op;
      bus.rs_addr     = head_instr[25:21];
      bus.rt_addr     = head_instr[20:16];
      bus.rd_addr     = head_instr[15:11];
      bus.shamt       = head_instr[10:6];
      bus.func        = head_instr[5:0];
      bus.imm         = head_instr[15:0];
      bus.imm_ext     = ext_imm(head_op, head_instr[15:0]);
      bus.instr_index = head_instr[25:0];
      bus.jump_target = {jump_hi, head_instr[25:0], 2'b00};
      bus.instr_class = classify(head_op);
      bus.out_pc      = head_pc;
`ifdef DECODE_ILLEGAL_EN
      bus.illegal     = ~is_legal_op(head_op);
`endif
    end
  end

`ifdef DECODE_ILLEGAL_EN
  // Sticky record of any illegal entry handed to execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen <= 1'b0;
    end else if (pop && bus.illegal) begin
      illegal_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
`timescale 1ns/1ps
module tb_instr_decode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  instr_decode_queue_if #(.XLEN(XLEN)) bus ();
`ifdef DECODE_ILLEGAL_EN
  logic illegal_seen;
`endif

  instr_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef DECODE_ILLEGAL_EN
    , .illegal_seen (illegal_seen)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain FIFO of accepted words plus sticky flag
  logic [31:0]     mq_instr[$];
  logic [XLEN-1:0] mq_pc[$];
  logic [31:0]     m_accepted[$];
  bit              m_seen = 1'b0;

  function automatic logic [XLEN-1:0] ref_imm_ext(input logic [31:0] w);
    int unsigned op = w[31:26];
    longint imm = w[15:0];
    longint v;
    if (op == 12 || op == 13 || op == 14) v = imm;
    else if (op == 15) v = (imm >= 32768) ? imm * 65536 - 64'sd4294967296 : imm * 65536;
    else v = (imm >= 32768) ? imm - 65536 : imm;
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] ref_jump(input logic [31:0] w, input logic [XLEN-1:0] pc);
    logic [XLEN-1:0] pc4;
    pc4 = pc + XLEN'(4);
    return (pc4 & ~XLEN'(32'h0FFF_FFFF)) | XLEN'((w & 32'h03FF_FFFF) << 2);
  endfunction

  function automatic logic [1:0] ref_class(input logic [31:0] w);
    int unsigned op = w[31:26];
    if (op == 0) return 2'd0;
    if (op == 2 || op == 3) return 2'd1;
    return 2'd2;
  endfunction

  function automatic bit ref_illegal(input logic [31:0] w);
    int unsigned op = w[31:26];
    return !(op inside {'h00, 'h02, 'h03, 'h04, 'h05, 'h08, 'h09, 'h0A, 'h0B, 'h0C,
                        'h0D, 'h0E, 'h0F, 'h20, 'h23, 'h24, 'h25, 'h28, 'h29, 'h2B});
  endfunction

  // One clock: drive inputs, step the model by the same rules, settle outputs.
  task automatic tick(input bit v, input logic [31:0] w, input logic [XLEN-1:0] pc,
                      input bit rdy, input bit fl);
    bit do_push, do_pop;
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    flush         = fl;
    do_push = v && (mq_instr.size() < DEPTH);
    do_pop  = rdy && (mq_instr.size() > 0);
    if (do_pop && ref_illegal(mq_instr[0])) m_seen = 1'b1;
    @(posedge clk);
    #1;
    if (fl) begin
      mq_instr.delete();
      mq_pc.delete();
    end else begin
      if (do_pop) begin
        void'(mq_instr.pop_front());
        void'(mq_pc.pop_front());
      end
      if (do_push) begin
        mq_instr.push_back(w);
        mq_pc.push_back(pc);
        m_accepted.push_back(w);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 0; flush = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_checks++; if ({bus.opcode, bus.instr_index, bus.imm_ext, bus.jump_target, bus.out_pc, bus.instr_class} !== '0)
      begin n_fail++; $display("FAIL reset_decoded_zero got op=%h idx=%h ext=%h jt=%h pc=%h exp=0",
        bus.opcode, bus.instr_index, bus.imm_ext, bus.jump_target, bus.out_pc); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    tick(1, 32'h012A_4020, 32'h0040_0000, 0, 0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rtype_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if ({bus.opcode, bus.rs_addr, bus.rt_addr, bus.rd_addr, bus.func} !== {6'd0, 5'd9, 5'd10, 5'd8, 6'h20})
      begin n_fail++; $display("FAIL rtype_fields got op=%h rs=%0d rt=%0d rd=%0d fn=%h exp 0/9/10/8/20",
        bus.opcode, bus.rs_addr, bus.rt_addr, bus.rd_addr, bus.func); end
    n_checks++; if (bus.instr_class !== 2'b00) begin n_fail++; $display("FAIL rtype_class got=%b exp=00", bus.instr_class); end
    n_checks++; if (bus.out_pc !== 32'h0040_0000) begin n_fail++; $display("FAIL rtype_pc got=%h exp=00400000", bus.out_pc); end
    tick(0, '0, '0, 1, 0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rtype_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_imm();
    logic [31:0] words[3] = '{32'h2008_FFFF, 32'h3408_FFFF, 32'h3C08_1234};
    logic [31:0] exps[3]  = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h1234_0000};
    for (int i = 0; i < 3; i++) begin
      tick(1, words[i], 32'h0000_1000, 0, 0);
      n_checks++; if (bus.imm_ext !== exps[i]) begin n_fail++; $display("FAIL imm_ext_%0d got=%h exp=%h", i, bus.imm_ext, exps[i]); end
      tick(0, '0, '0, 1, 0);
    end
  endtask

  task automatic test_jump();
    tick(1, 32'h0810_0004, 32'h3FFF_FFFC, 0, 0);
    n_checks++; if (bus.jump_target !== 32'h4040_0010) begin n_fail++; $display("FAIL jump_target got=%h exp=40400010", bus.jump_target); end
    n_checks++; if (bus.instr_class !== 2'b01) begin n_fail++; $display("FAIL jump_class got=%b exp=01", bus.instr_class); end
    tick(0, '0, '0, 1, 0);
  endtask

  task automatic test_full_drain();
    logic [31:0] seen[$];
    int k = 0;
    m_accepted.delete();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, 32'h2000_0000 | k, 32'h100 + 4 * k, 0, 0);
      k++;
    end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
    bus.in_valid = 1; bus.out_ready = 1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready_pop got=%b exp=0", bus.in_ready); end
    for (int c = 0; c < 3 * DEPTH + 4; c++) begin
      bit v = (c < 2 * DEPTH + 2);
      if (bus.out_valid) seen.push_back({bus.opcode, bus.instr_index});
      tick(v, 32'h2000_0000 | k, 32'h100 + 4 * k, 1, 0);
      if (v && m_accepted.size() > 0 && m_accepted[m_accepted.size() - 1] == (32'h2000_0000 | k)) k++;
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", bus.out_valid); end
    n_checks++; if (seen.size() != m_accepted.size()) begin n_fail++; $display("FAIL drain_count got=%0d exp=%0d", seen.size(), m_accepted.size()); end
    else begin
      for (int i = 0; i < seen.size(); i++) begin
        n_checks++; if (seen[i] !== m_accepted[i]) begin n_fail++; $display("FAIL drain_order_%0d got=%h exp=%h", i, seen[i], m_accepted[i]); end
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < DEPTH - 1; i++) tick(1, 32'h2000_AA00 | i, 32'h200, 0, 0);
    tick(1, 32'h2000_DEAD, 32'h204, 0, 1);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
    tick(0, '0, '0, 0, 0);
    tick(1, 32'h2000_1111, 32'h208, 0, 0);
    n_checks++; if ({bus.opcode, bus.instr_index} !== 32'h2000_1111) begin n_fail++; $display("FAIL flush_next_head got=%h exp=20001111", {bus.opcode, bus.instr_index}); end
    tick(0, '0, '0, 1, 0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after_pop got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    tick(1, 32'hFC00_0000, 32'h300, 0, 0);
`ifdef DECODE_ILLEGAL_EN
    n_checks++; if (bus.illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag got=%b exp=1", bus.illegal); end
    n_checks++; if (illegal_seen !== 1'b0) begin n_fail++; $display("FAIL illegal_seen_early got=%b exp=0", illegal_seen); end
    tick(0, '0, '0, 1, 0);
    n_checks++; if (illegal_seen !== 1'b1) begin n_fail++; $display("FAIL illegal_seen_set got=%b exp=1", illegal_seen); end
`else
    n_checks++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_tied got=%b exp=0", bus.illegal); end
    tick(0, '0, '0, 1, 0);
`endif
  endtask

  task automatic test_reset_mid();
    tick(1, 32'h2000_5555, 32'h400, 0, 0);
    #2 rst_n = 0;
    #1;
    mq_instr.delete(); mq_pc.delete(); m_seen = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got=%b exp=0", bus.out_valid); end
`ifdef DECODE_ILLEGAL_EN
    n_checks++; if (illegal_seen !== 1'b0) begin n_fail++; $display("FAIL midreset_seen got=%b exp=0", illegal_seen); end
`endif
    @(posedge clk); #1;
    rst_n = 1;
    tick(1, 32'h2000_6666, 32'h404, 0, 0);
    n_checks++; if ({bus.out_valid, bus.opcode, bus.instr_index} !== {1'b1, 32'h2000_6666})
      begin n_fail++; $display("FAIL midreset_first_push got=%b/%h exp=1/20006666", bus.out_valid, {bus.opcode, bus.instr_index}); end
    tick(0, '0, '0, 1, 0);
  endtask

  task automatic test_random();
    logic [5:0] ops[10] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h3F};
    for (int c = 0; c < 400; c++) begin
      logic [31:0] w, ew;
      logic [XLEN-1:0] pc, epc;
      bit ev;
      w  = {ops[$urandom_range(0, 9)], 26'($urandom)};
      pc = XLEN'($urandom);
      if ($urandom_range(0, 7) == 0) pc = XLEN'(32'hFFFF_FFFC);
      else if ($urandom_range(0, 7) == 0) pc = XLEN'(32'h0FFF_FFFC);
      tick($urandom_range(0, 3) != 0, w, pc, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      ev  = mq_instr.size() > 0;
      ew  = ev ? mq_instr[0] : 32'h0;
      epc = ev ? mq_pc[0] : '0;
      n_checks++; if (bus.out_valid !== ev) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.out_valid, ev); end
      n_checks++; if (bus.in_ready !== (mq_instr.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, mq_instr.size() < DEPTH); end
      n_checks++; if ({bus.opcode, bus.rs_addr, bus.rt_addr, bus.rd_addr, bus.shamt, bus.func} !== ew)
        begin n_fail++; $display("FAIL rnd_fields c=%0d got=%h exp=%h", c, {bus.opcode, bus.rs_addr, bus.rt_addr, bus.rd_addr, bus.shamt, bus.func}, ew); end
      n_checks++; if ({bus.imm, bus.instr_index} !== {ew[15:0], ew[25:0]}) begin n_fail++; $display("FAIL rnd_imm_idx c=%0d got=%h/%h exp=%h", c, bus.imm, bus.instr_index, ew); end
      n_checks++; if (bus.imm_ext !== (ev ? ref_imm_ext(ew) : '0)) begin n_fail++; $display("FAIL rnd_imm_ext c=%0d got=%h exp=%h", c, bus.imm_ext, ev ? ref_imm_ext(ew) : '0); end
      n_checks++; if (bus.jump_target !== (ev ? ref_jump(ew, epc) : '0)) begin n_fail++; $display("FAIL rnd_jump c=%0d got=%h exp=%h", c, bus.jump_target, ev ? ref_jump(ew, epc) : '0); end
      n_checks++; if (bus.instr_class !== (ev ? ref_class(ew) : 2'b00)) begin n_fail++; $display("FAIL rnd_class c=%0d got=%b exp=%b", c, bus.instr_class, ev ? ref_class(ew) : 2'b00); end
      n_checks++; if (bus.out_pc !== epc) begin n_fail++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, bus.out_pc, epc); end
`ifdef DECODE_ILLEGAL_EN
      n_checks++; if (bus.illegal !== (ev && ref_illegal(ew))) begin n_fail++; $display("FAIL rnd_illegal c=%0d got=%b exp=%b", c, bus.illegal, ev && ref_illegal(ew)); end
      n_checks++; if (illegal_seen !== m_seen) begin n_fail++; $display("FAIL rnd_seen c=%0d got=%b exp=%b", c, illegal_seen, m_seen); end
`else
      n_checks++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL rnd_illegal c=%0d got=%b exp=0", c, bus.illegal); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_jump();
    test_full_drain();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
